seg7_scan: RTL

Time-multiplexed scan controller for a common-segment 4-digit 7-segment display. It is the stage directly upstream of the `seg7dec` decoder. It latches a multi-digit hex value, walks the digits at a fixed slot rate, and presents one nibble at a time to a single `seg7dec` instance together with a one-hot digit select. The shared segment bus needs no per-digit decoder. Display updates are tear-free (frame-aligned), with optional leading-zero blanking and an anti-ghosting guard interval.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_scan.sv | 122 ++++++++++++
 2 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and helpers for the 7-segment scan path
//
// Contents:
//   nibble_t    - one hex digit as presented to the seg7dec decoder
//   MAX_DIGITS  - widest display lz_mask can describe
//   SEL_OFF     - level of a DIG_SEL bit that turns its digit off
//   lz_mask()   - per-digit leading-zero blank vector for a packed hex value
package seg7_pkg;

    typedef logic [3:0] nibble_t;

    localparam int   MAX_DIGITS = 16;
    localparam logic SEL_OFF    = 1'b1;

    // Bit i is set when nibbles i..digits-1 of value are all zero.
    // Digit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] value,
        input int                      digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits) begin
                zero_above = zero_above && (value[4*i +: 4] == 4'h0);
                mask[i]    = zero_above && (i != 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed scan controller for a multi-digit 7-segment display
//
// Ports:
//   CLK       in   system clock
//   RST_N     in   asynchronous active-low reset
//   LOAD      in   single-cycle strobe capturing VALUE into the shadow register
//   VALUE     in   4*DIGITS hex value, digit 0 in bits [3:0]
//   BLANK_LZ  in   leading-zero blanking enable, taken at each frame boundary
//   NIBBLE    out  hex digit for the current slot, drives the seg7dec decoder
//   DIG_SEL   out  one-hot active-low digit enable, all ones = display dark
//   FRAME     out  one-cycle pulse in the first cycle of every frame
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] VALUE,
    input  logic                BLANK_LZ,
    output nibble_t             NIBBLE,
    output logic [DIGITS-1:0]   DIG_SEL,
    output logic                FRAME
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int VW = 4 * MAX_DIGITS;

    localparam logic [PW-1:0]     PCNT_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0]     GUARD_LIM   = PW'(GUARD);
    localparam logic [IW-1:0]     IDX_LAST    = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_ALL_OFF = {DIGITS{SEL_OFF}};

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic                  pend_q, pend_d;
    logic                  blz_q, blz_d;
    nibble_t               nibble_q, nibble_d;
    logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
    logic                  frame_q, frame_d;

    logic                  tick;
    logic                  boundary;
    logic [MAX_DIGITS-1:0] blank_vec;
    logic [MAX_DIGITS-1:0] onehot;
    logic                  slot_blank;

    always_comb begin
        tick     = (pcnt_q == PCNT_LAST);
        boundary = tick && (idx_q == IDX_LAST);

        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        idx_d  = idx_q;
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        // Last LOAD before the boundary wins; the display only moves at the boundary.
        shadow_d = LOAD ? VALUE : shadow_q;
        pend_d   = pend_q | LOAD;
        disp_d   = disp_q;
        blz_d    = blz_q;
        if (boundary) begin
            blz_d  = BLANK_LZ;
            pend_d = 1'b0;
            // A LOAD landing on the boundary goes straight to the display.
            if (LOAD) begin
                disp_d = VALUE;
            end else if (pend_q) begin
                disp_d = shadow_q;
            end
        end

        frame_d = boundary;

        // Outputs are registered from next state so they line up with pcnt_q/idx_q.
        nibble_d   = disp_d[4*idx_d +: 4];
        blank_vec  = lz_mask(VW'(disp_d), DIGITS);
        onehot     = MAX_DIGITS'(1) << idx_d;
        slot_blank = blz_d && (|(blank_vec & onehot));
        if ((pcnt_d < GUARD_LIM) || slot_blank) begin
            dig_sel_d = SEL_ALL_OFF;
        end else begin
            dig_sel_d = SEL_ALL_OFF ^ onehot[DIGITS-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt_q    <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pend_q    <= 1'b0;
            blz_q     <= 1'b0;
            nibble_q  <= '0;
            dig_sel_q <= SEL_ALL_OFF;
            frame_q   <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            blz_q     <= blz_d;
            nibble_q  <= nibble_d;
            dig_sel_q <= dig_sel_d;
            frame_q   <= frame_d;
        end
    end

    assign NIBBLE  = nibble_q;
    assign DIG_SEL = dig_sel_q;
    assign FRAME   = frame_q;

endmodule
